// File: rtl/riscv_cache_hit.sv
// riscv_cache_hit: data-cache hit/miss stage; acks hits, writes hit lines, and runs victim line fills on misses.
module riscv_cache_hit #(
  parameter int XLEN = 32,
  parameter int PLEN = XLEN,
  parameter int SIZE = 64,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS = 2,
  localparam int BLK_OFFS_BITS = $clog2(BLOCK_SIZE),
  localparam int IDX_BITS = $clog2(SIZE*1024/BLOCK_SIZE/WAYS),
  localparam int TAG_BITS = PLEN - IDX_BITS - BLK_OFFS_BITS,
  localparam int LINE = BLOCK_SIZE*8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     req_i,
  input  logic                     wreq_i,
  input  logic [PLEN-1:0]          adr_i,
  input  logic [XLEN/8-1:0]        be_i,
  input  logic [XLEN-1:0]          d_i,
  input  logic                     pagefault_i,
  input  logic [TAG_BITS-1:0]      core_tag_i,
  input  logic [WAYS*TAG_BITS-1:0] tag_i,
  input  logic [WAYS-1:0]          valid_i,
  input  logic [WAYS*LINE-1:0]     line_i,
  output logic                     stall_o,
  output logic                     ack_o,
  output logic                     err_o,
  output logic [XLEN-1:0]          q_o,
  output logic                     mem_we_o,
  output logic [WAYS-1:0]          mem_way_o,
  output logic [XLEN/8-1:0]        mem_be_o,
  output logic [XLEN-1:0]          mem_d_o,
  output logic                     fill_req_o,
  output logic [PLEN-1:0]          fill_adr_o,
  output logic [WAYS-1:0]          fill_way_o,
  input  logic                     fill_ack_i,
  input  logic                     fill_done_i,
  input  logic                     fill_err_i
);
  localparam int WB = $clog2(XLEN/8);
  localparam int CW = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam logic [2:0] ARMED = 3'd0, MISS_REQ = 3'd1, WAIT_FILL = 3'd2, RECHECK = 3'd3, ERR = 3'd4;
  logic [2:0] state;
  logic flushed, inv, armed, take, miss, we, unused;
  logic [CW-1:0] cnt, cnt_nxt, vic;
  logic [WAYS-1:0] hit, hit_way;
  logic [LINE-1:0] hit_line;
  logic [BLK_OFFS_BITS-WB-1:0] widx;
  logic [XLEN-1:0] word;
  // descending scan so the lowest-index hit and lowest-index invalid way win
  always_comb begin
    hit = '0;
    hit_way = '0;
    hit_line = '0;
    vic = cnt;
    inv = 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      hit[w] = req_i & ~pagefault_i & valid_i[w] & (tag_i[w*TAG_BITS +: TAG_BITS] == core_tag_i);
      if (hit[w]) begin
        hit_way = '0;
        hit_way[w] = 1'b1;
        hit_line = line_i[w*LINE +: LINE];
      end
      if (!valid_i[w]) begin
        vic = CW'(w);
        inv = 1'b1;
      end
    end
  end
  assign widx = adr_i[BLK_OFFS_BITS-1:WB];
  assign word = XLEN'(hit_line >> {widx, {$clog2(XLEN){1'b0}}});
  assign cnt_nxt = (cnt == CW'(WAYS-1)) ? '0 : cnt + 1'b1;
  assign armed = state == ARMED;
  assign take = armed & req_i & ~flush_i;
  assign miss = take & ~pagefault_i & ~|hit;
  assign we = take & wreq_i & |hit;
  assign stall_o = ~armed | miss;
  assign mem_we_o = we;
  assign mem_way_o = we ? hit_way : '0;
  assign mem_be_o = we ? be_i : '0;
  assign mem_d_o = we ? d_i : '0;
  assign unused = ^adr_i[WB-1:0];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= ARMED;
      flushed <= 1'b0;
      cnt <= '0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      q_o <= '0;
      fill_req_o <= 1'b0;
      fill_adr_o <= '0;
      fill_way_o <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      q_o <= '0;
      case (state)
        ARMED: begin
          ack_o <= take & (pagefault_i | |hit);
          err_o <= take & pagefault_i;
          q_o <= (take & ~wreq_i & |hit) ? word : '0;
          if (miss) begin
            state <= MISS_REQ;
            fill_req_o <= 1'b1;
            fill_adr_o <= {adr_i[PLEN-1:BLK_OFFS_BITS], {BLK_OFFS_BITS{1'b0}}};
            fill_way_o <= WAYS'(1) << vic;
            if (!inv) cnt <= cnt_nxt;
          end
        end
        MISS_REQ: begin
          flushed <= flushed | flush_i;
          if (fill_ack_i) begin
            fill_req_o <= 1'b0;
            state <= WAIT_FILL;
          end
        end
        // a flushed request still completes the fill but never acks
        WAIT_FILL: begin
          flushed <= flushed | flush_i;
          if (fill_err_i) begin
            state <= ERR;
            ack_o <= ~(flushed | flush_i);
            err_o <= ~(flushed | flush_i);
          end else if (fill_done_i) state <= RECHECK;
        end
        default: begin
          state <= ARMED;
          flushed <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_riscv_cache_hit.sv
// tb_riscv_cache_hit: vector table, hand-written fill sequences and randomized hit checks for riscv_cache_hit.
module tb_riscv_cache_hit;
  localparam int TAGB = 17, LINE = 256;
  logic clk = 1'b0, rst_i = 1'b1;
  logic flush_i, req_i, wreq_i, pagefault_i, fill_ack_i, fill_done_i, fill_err_i;
  logic [31:0] adr_i, d_i, q_o, mem_d_o, fill_adr_o;
  logic [3:0] be_i, mem_be_o;
  logic [TAGB-1:0] core_tag_i;
  logic [2*TAGB-1:0] tag_i;
  logic [1:0] valid_i, mem_way_o, fill_way_o;
  logic [2*LINE-1:0] line_i;
  logic stall_o, ack_o, err_o, mem_we_o, fill_req_o;
  int total = 0, bad = 0;
  logic [TAGB-1:0] m_tag [2];
  logic [31:0] m_line [2][8];

  always #5 clk = ~clk;

  riscv_cache_hit dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .req_i(req_i), .wreq_i(wreq_i),
    .adr_i(adr_i), .be_i(be_i), .d_i(d_i), .pagefault_i(pagefault_i), .core_tag_i(core_tag_i),
    .tag_i(tag_i), .valid_i(valid_i), .line_i(line_i), .stall_o(stall_o), .ack_o(ack_o),
    .err_o(err_o), .q_o(q_o), .mem_we_o(mem_we_o), .mem_way_o(mem_way_o), .mem_be_o(mem_be_o),
    .mem_d_o(mem_d_o), .fill_req_o(fill_req_o), .fill_adr_o(fill_adr_o), .fill_way_o(fill_way_o),
    .fill_ack_i(fill_ack_i), .fill_done_i(fill_done_i), .fill_err_i(fill_err_i)
  );

  typedef struct {
    logic req, wreq, pf, flush;
    logic [1:0] valid, match;
    logic [2:0] wd;
    logic e_ack, e_err, e_we;
    logic [1:0] e_way;
    logic [31:0] e_q;
  } vec_t;
  vec_t tv [11];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  task automatic init_lines();
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 8; k++) m_line[w][k] = 32'hA000_0000 + 32'(w * 256 + k);
    m_line[1][3] = 32'hDEADBEEF;
  endtask

  task automatic pack();
    for (int w = 0; w < 2; w++) begin
      tag_i[w*TAGB +: TAGB] = m_tag[w];
      for (int k = 0; k < 8; k++) line_i[w*LINE + k*32 +: 32] = m_line[w][k];
    end
  endtask

  task automatic set_adr(input logic [TAGB-1:0] tg, input logic [2:0] wd);
    adr_i = {tg, 10'($urandom), wd, 2'b00};
    core_tag_i = tg;
  endtask

  task automatic set_match(input logic [1:0] match);
    for (int w = 0; w < 2; w++) m_tag[w] = match[w] ? core_tag_i : core_tag_i ^ 17'h1;
  endtask

  task automatic apply_check(input string n, input logic e_we, input logic [1:0] e_way,
                             input logic e_ack, input logic e_err, input logic [31:0] e_q);
    pack();
    #1;
    chk({n, ".we"}, 64'(mem_we_o), 64'(e_we));
    chk({n, ".way"}, 64'(mem_way_o), 64'(e_way));
    chk({n, ".be"}, 64'(mem_be_o), 64'(e_we ? be_i : 4'h0));
    chk({n, ".d"}, 64'(mem_d_o), 64'(e_we ? d_i : 32'h0));
    chk({n, ".stall"}, 64'(stall_o), 64'(0));
    chk({n, ".fill_req"}, 64'(fill_req_o), 64'(0));
    @(posedge clk);
    #1;
    chk({n, ".ack"}, 64'(ack_o), 64'(e_ack));
    chk({n, ".err"}, 64'(err_o), 64'(e_err));
    chk({n, ".q"}, 64'(q_o), 64'(e_q));
  endtask

  // kind: 0 done, 1 err+done, 2 flush then done, 3 flush then err
  task automatic run_miss(input string n, input logic [1:0] vld, input logic [1:0] e_vway,
                          input int hold, input int kind);
    logic [31:0] a;
    logic is_err;
    is_err = (kind == 1) || (kind == 3);
    req_i = 1'b1; wreq_i = 1'b0; pagefault_i = 1'b0; flush_i = 1'b0; valid_i = vld;
    set_adr(17'h0F0F0, 3'd3);
    set_match(2'b00);
    pack();
    a = adr_i;
    #1;
    chk({n, ".miss_stall"}, 64'(stall_o), 64'(1));
    chk({n, ".miss_we"}, 64'(mem_we_o), 64'(0));
    @(posedge clk);
    #1;
    chk({n, ".fill_req"}, 64'(fill_req_o), 64'(1));
    chk({n, ".fill_way"}, 64'(fill_way_o), 64'(e_vway));
    chk({n, ".fill_adr"}, 64'(fill_adr_o), 64'((a / 32) * 32));
    chk({n, ".req_stall"}, 64'(stall_o), 64'(1));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({n, ".hold_req"}, 64'(fill_req_o), 64'(1));
      chk({n, ".hold_way"}, 64'(fill_way_o), 64'(e_vway));
      chk({n, ".hold_adr"}, 64'(fill_adr_o), 64'((a / 32) * 32));
    end
    fill_ack_i = 1'b1;
    @(posedge clk);
    #1;
    fill_ack_i = 1'b0;
    chk({n, ".req_drop"}, 64'(fill_req_o), 64'(0));
    chk({n, ".wait_ack"}, 64'(ack_o), 64'(0));
    if (kind >= 2) begin
      flush_i = 1'b1;
      req_i = 1'b0;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({n, ".wait_stall"}, 64'(stall_o), 64'(1));
    fill_done_i = 1'b1;
    fill_err_i = is_err;
    @(posedge clk);
    #1;
    fill_done_i = 1'b0;
    fill_err_i = 1'b0;
    if (is_err) begin
      chk({n, ".err_ack"}, 64'(ack_o), 64'(kind == 1));
      chk({n, ".err_err"}, 64'(err_o), 64'(kind == 1));
      req_i = 1'b0;
      @(posedge clk);
      #1;
      chk({n, ".post_err_ack"}, 64'(ack_o), 64'(0));
      chk({n, ".post_err_stall"}, 64'(stall_o), 64'(0));
    end else begin
      chk({n, ".recheck_ack"}, 64'(ack_o), 64'(0));
      chk({n, ".recheck_stall"}, 64'(stall_o), 64'(1));
      valid_i = vld | e_vway;
      set_match(e_vway);
      pack();
      @(posedge clk);
      #1;
      chk({n, ".armed_stall"}, 64'(stall_o), 64'(0));
      chk({n, ".armed_ack"}, 64'(ack_o), 64'(0));
      @(posedge clk);
      #1;
      chk({n, ".final_ack"}, 64'(ack_o), 64'(kind == 0));
      chk({n, ".final_q"}, 64'(q_o), 64'(kind == 0 ? m_line[e_vway[1]][3] : 32'h0));
      req_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    flush_i = 1'b0; req_i = 1'b0; wreq_i = 1'b0; pagefault_i = 1'b0;
    fill_ack_i = 1'b0; fill_done_i = 1'b0; fill_err_i = 1'b0;
    be_i = 4'b0011; d_i = 32'h1234; valid_i = 2'b00;
    init_lines();
    set_adr(17'h1ABCD, 3'd0);
    set_match(2'b00);
    pack();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ack", 64'(ack_o), 64'(0));
    chk("rst.err", 64'(err_o), 64'(0));
    chk("rst.q", 64'(q_o), 64'(0));
    chk("rst.fill_req", 64'(fill_req_o), 64'(0));
    chk("rst.fill_way", 64'(fill_way_o), 64'(0));
    chk("rst.fill_adr", 64'(fill_adr_o), 64'(0));
    chk("rst.stall", 64'(stall_o), 64'(0));
    chk("rst.we", 64'(mem_we_o), 64'(0));
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 3'd3, 1'b1, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10, 3'd0, 1'b1, 1'b0, 1'b1, 2'b10, 32'h0};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 3'd5, 1'b1, 1'b0, 1'b0, 2'b00, 32'hA0000005};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b11, 3'd1, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 3'd2, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 3'd2, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 3'd4, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b11, 3'd7, 1'b1, 1'b0, 1'b0, 2'b00, 32'hA0000007};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b11, 3'd2, 1'b1, 1'b0, 1'b0, 2'b00, 32'hA0000102};
    tv[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b11, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0};
    tv[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2'b11, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
    for (int i = 0; i < 11; i++) begin
      req_i = tv[i].req; wreq_i = tv[i].wreq; pagefault_i = tv[i].pf; flush_i = tv[i].flush;
      valid_i = tv[i].valid;
      set_adr(17'h1ABCD ^ 17'(i), tv[i].wd);
      set_match(tv[i].match);
      apply_check($sformatf("vec%0d", i), tv[i].e_we, tv[i].e_way, tv[i].e_ack, tv[i].e_err, tv[i].e_q);
    end
    req_i = 1'b0; wreq_i = 1'b0; pagefault_i = 1'b0; flush_i = 1'b0;
    run_miss("miss_cnt0", 2'b11, 2'b01, 0, 0);
    run_miss("victim_inv", 2'b01, 2'b10, 1, 0);
    run_miss("miss_cnt1", 2'b11, 2'b10, 3, 0);
    run_miss("flush_wait", 2'b11, 2'b01, 0, 2);
    run_miss("fill_err", 2'b11, 2'b10, 0, 1);
    run_miss("flush_err", 2'b00, 2'b01, 0, 3);
    run_miss("cnt_wrap", 2'b11, 2'b01, 0, 0);
    req_i = 1'b1; valid_i = 2'b11;
    set_adr(17'h05555, 3'd1);
    set_match(2'b00);
    pack();
    @(posedge clk);
    #1;
    chk("midrst.fill_req_before", 64'(fill_req_o), 64'(1));
    chk("midrst.fill_way_before", 64'(fill_way_o), 64'(2'b10));
    req_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("midrst.fill_req", 64'(fill_req_o), 64'(0));
    chk("midrst.fill_way", 64'(fill_way_o), 64'(0));
    chk("midrst.stall", 64'(stall_o), 64'(0));
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    run_miss("post_rst", 2'b11, 2'b01, 0, 0);
    for (int n = 0; n < 300; n++) begin
      logic [TAGB-1:0] ct;
      logic [2:0] wd;
      int hw;
      logic hit_any, e_ack, e_err, e_we;
      logic [1:0] e_way;
      logic [31:0] e_q;
      ct = 17'($urandom);
      wd = 3'($urandom);
      req_i = ($urandom % 4) != 0;
      wreq_i = 1'($urandom);
      pagefault_i = ($urandom % 8) == 0;
      flush_i = ($urandom % 8) == 0;
      be_i = 4'($urandom);
      d_i = $urandom;
      set_adr(ct, wd);
      valid_i = 2'($urandom);
      for (int w = 0; w < 2; w++) begin
        m_tag[w] = ($urandom % 2 != 0) ? ct : 17'($urandom);
        for (int k = 0; k < 8; k++) m_line[w][k] = $urandom;
      end
      hw = -1;
      for (int w = 0; w < 2; w++)
        if (hw < 0 && valid_i[w] && m_tag[w] == ct) hw = w;
      if (req_i && !pagefault_i && !flush_i && hw < 0) begin
        hw = int'($urandom % 2);
        valid_i[hw] = 1'b1;
        m_tag[hw] = ct;
      end
      hit_any = req_i && !pagefault_i && hw >= 0;
      e_ack = req_i && !flush_i && (pagefault_i || hit_any);
      e_err = req_i && !flush_i && pagefault_i;
      e_we = req_i && !flush_i && hit_any && wreq_i;
      e_way = e_we ? 2'(1 << hw) : 2'b00;
      e_q = (e_ack && hit_any && !wreq_i) ? m_line[hw < 0 ? 0 : hw][wd] : 32'h0;
      apply_check($sformatf("rnd%0d", n), e_we, e_way, e_ack, e_err, e_q);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
